// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order imem word requests under a credit limit,
// buffers returned words with their PC and hands them to decode; redirects flush and drop stale words.
module fetch_unit_chk #(
  parameter int CW     = 3,
  parameter int QDEPTH = 4
) (
  input logic          clk,
  input logic          rst_n,
  input logic          push,
  input logic [CW-1:0] count,
  input logic [CW-1:0] outstanding,
  input logic [CW-1:0] dropCnt
);
  localparam logic [CW-1:0] LIMIT = CW'(QDEPTH);

  a_noPushWhenFull: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (count == LIMIT)));
  a_countersBounded: assert property (@(posedge clk) disable iff (!rst_n)
    (count <= LIMIT) && (outstanding <= LIMIT) && (dropCnt <= LIMIT));
endmodule

module fetch_unit #(
  parameter int                INSTR_LEN = 32,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = {ADDR_W{1'b0}},
  parameter int                QDEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [ADDR_W-1:0]    imem_req_addr,
  input  logic                 imem_rsp_valid,
  input  logic [INSTR_LEN-1:0] imem_rsp_data,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [INSTR_LEN-1:0] instr,
  output logic [ADDR_W-1:0]    instr_pc,
  input  logic                 redirect_valid,
  input  logic [ADDR_W-1:0]    redirect_pc,
  input  logic                 halt,
  output logic                 busy
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(INSTR_LEN / 8);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(2'd3);
  localparam logic [CW:0]       CREDIT     = (CW + 1)'(QDEPTH);
  localparam logic [CW-1:0]     CNT_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0]     CNT_ONE    = CW'(1'b1);
  localparam logic [PW-1:0]     PTR_ZERO   = {PW{1'b0}};
  localparam logic [PW-1:0]     PTR_ONE    = PW'(1'b1);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_RUN   = 2'd1,
    S_HALT  = 2'd2
  } stateT;

  stateT                stateR, stateNextS;
  logic [ADDR_W-1:0]    pcR, rspPcR, alignedPcS;
  logic [CW-1:0]        countR, outstandingR, dropCntR, outstandingNextS;
  logic [CW:0]          occupancyS;
  logic [PW-1:0]        headR, tailR;
  logic [INSTR_LEN-1:0] instrMemR [QDEPTH];
  logic [ADDR_W-1:0]    pcMemR    [QDEPTH];
  logic                 reqValidS, acceptS, dropS, pushS, popS;

  // Next-state logic: halt is sampled every cycle, redirect never changes state
  always_comb begin
    stateNextS = stateR;
    case (stateR)
      S_RESET: stateNextS = S_RUN;
      S_RUN:   if (halt) stateNextS = S_HALT; else stateNextS = S_RUN;
      S_HALT:  if (halt) stateNextS = S_HALT; else stateNextS = S_RUN;
      default: stateNextS = S_RESET;
    endcase
  end

  // Credit covers both queued words and words still in flight, so a push always finds room
  assign occupancyS       = {1'b0, countR} + {1'b0, outstandingR};
  assign reqValidS        = (stateR == S_RUN) && !redirect_valid && (occupancyS < CREDIT);
  assign acceptS          = reqValidS && imem_req_ready;
  assign dropS            = imem_rsp_valid && (redirect_valid || (dropCntR != CNT_ZERO));
  assign pushS            = imem_rsp_valid && !dropS;
  assign popS             = (countR != CNT_ZERO) && instr_ready;
  assign outstandingNextS = outstandingR + (acceptS ? CNT_ONE : CNT_ZERO)
                                         - (imem_rsp_valid ? CNT_ONE : CNT_ZERO);
  assign alignedPcS       = redirect_pc & ALIGN_MASK;

  // FSM state, request PC and the PC of the oldest outstanding request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateR <= S_RESET;
      pcR    <= RESET_PC;
      rspPcR <= RESET_PC;
    end else begin
      stateR <= stateNextS;
      if (redirect_valid) begin
        pcR    <= alignedPcS;
        rspPcR <= alignedPcS;
      end else begin
        if (acceptS) pcR <= pcR + STEP;
        else pcR <= pcR;
        if (pushS) rspPcR <= rspPcR + STEP;
        else rspPcR <= rspPcR;
      end
    end
  end

  // In-flight and stale-response accounting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstandingR <= CNT_ZERO;
      dropCntR     <= CNT_ZERO;
    end else begin
      outstandingR <= outstandingNextS;
      if (redirect_valid) dropCntR <= outstandingNextS;
      else if (dropS) dropCntR <= dropCntR - CNT_ONE;
      else dropCntR <= dropCntR;
    end
  end

  // Instruction queue; a redirect empties it regardless of same-cycle push or pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      headR  <= PTR_ZERO;
      tailR  <= PTR_ZERO;
      countR <= CNT_ZERO;
      for (int i = 0; i < QDEPTH; i++) begin
        instrMemR[i] <= {INSTR_LEN{1'b0}};
        pcMemR[i]    <= {ADDR_W{1'b0}};
      end
    end else if (redirect_valid) begin
      headR  <= PTR_ZERO;
      tailR  <= PTR_ZERO;
      countR <= CNT_ZERO;
    end else begin
      if (pushS) begin
        instrMemR[tailR] <= imem_rsp_data;
        pcMemR[tailR]    <= rspPcR;
        tailR            <= tailR + PTR_ONE;
      end else begin
        tailR <= tailR;
      end
      if (popS) headR <= headR + PTR_ONE;
      else headR <= headR;
      case ({pushS, popS})
        2'b10:   countR <= countR + CNT_ONE;
        2'b01:   countR <= countR - CNT_ONE;
        default: countR <= countR;
      endcase
    end
  end

  assign imem_req_valid = reqValidS;
  assign imem_req_addr  = pcR;
  assign instr_valid    = (countR != CNT_ZERO);
  assign instr          = instrMemR[headR];
  assign instr_pc       = pcMemR[headR];
  assign busy           = (outstandingR != CNT_ZERO) || (countR != CNT_ZERO);

  fetch_unit_chk #(.CW(CW), .QDEPTH(QDEPTH)) chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (pushS),
    .count       (countR),
    .outstanding (outstandingR),
    .dropCnt     (dropCntR)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: an in-order memory with variable latency plus a queue-level
// model of which instruction words decode must see, checked every cycle.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt, busy;

  fetch_unit #(.INSTR_LEN(32), .ADDR_W(32), .RESET_PC(32'h0), .QDEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    bit          stale;
    int          due;
  } flightT;

  flightT      mOut[$];   // requests accepted by memory, oldest first
  logic [31:0] mQ[$];     // PCs of words decode should currently see, head first
  logic [31:0] mPc;
  int          lastDue, cyc;
  bit          haltLast;
  int          nCmp, nFail;
  int          readyPct, instrReadyPct, redirPct, latMin, latMax, haltCfg;
  bit          useFixed;
  logic [31:0] fixedTarget;
  bit          seen;

  function automatic logic [31:0] memWord(logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1234_5678;
  endfunction

  function automatic bit pct(int p);
    return int'($urandom_range(99)) < p;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chkb(string name, logic act, logic exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cfg(int rdy, int irdy, int rdr, int lmin, int lmax, int hc);
    readyPct = rdy; instrReadyPct = irdy; redirPct = rdr;
    latMin = lmin; latMax = lmax; haltCfg = hc;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    chkb("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chkb("rst_instr_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chkb("rst_busy", busy, 1'b0);
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; imem_req_ready = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; halt = 1'b0;
    mOut.delete(); mQ.delete();
    mPc = 32'h0; lastDue = 0; cyc = 0; haltLast = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chkb("sreset_no_req", imem_req_valid, 1'b0);
  endtask

  // One clock: drive inputs after the edge, check and advance the model on the falling edge
  task automatic step();
    bit     expReq, expVal, pop, acc;
    flightT e;
    int     d;
    @(posedge clk);
    cyc++;
    #1;
    if (mOut.size() > 0 && mOut[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memWord(mOut[0].pc);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    imem_req_ready = pct(readyPct);
    instr_ready    = pct(instrReadyPct);
    redirect_valid = pct(redirPct);
    if (useFixed) redirect_pc = fixedTarget;
    else if (pct(10)) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(15));
    else redirect_pc = $urandom & 32'h0000_3FFF;
    case (haltCfg)
      0:       halt = 1'b0;
      1:       halt = 1'b1;
      default: if (pct(4)) halt = !halt;
    endcase
    @(negedge clk);

    expReq = (cyc == 1 || !haltLast) && !redirect_valid && (mQ.size() + mOut.size() < 4);
    expVal = (mQ.size() != 0);
    chkb("req_valid", imem_req_valid, expReq);
    if (expReq) chk("req_addr", imem_req_addr, mPc);
    chkb("instr_valid", instr_valid, expVal);
    if (expVal) begin
      chk("instr_pc", instr_pc, mQ[0]);
      chk("instr", instr, memWord(mQ[0]));
    end
    chkb("busy", busy, (mQ.size() != 0) || (mOut.size() != 0));

    pop = expVal && instr_ready;
    acc = expReq && imem_req_ready;
    if (pop) void'(mQ.pop_front());
    if (imem_rsp_valid) begin
      e = mOut.pop_front();
      if (!e.stale && !redirect_valid) mQ.push_back(e.pc);
    end
    if (acc) begin
      d = cyc + int'($urandom_range(latMax, latMin));
      if (d <= lastDue) d = lastDue + 1;
      lastDue = d;
      e.pc = mPc; e.stale = 1'b0; e.due = d;
      mOut.push_back(e);
      mPc = mPc + 32'd4;
    end
    if (redirect_valid) begin
      mQ.delete();
      foreach (mOut[i]) mOut[i].stale = 1'b1;
      mPc = redirect_pc & ~32'd3;
    end
    haltLast = halt;
  endtask

  initial begin
    rst_n = 1'b1;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; imem_req_ready = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; halt = 1'b0;
    nCmp = 0; nFail = 0; useFixed = 1'b0; fixedTarget = 32'h0; cyc = 0;
    cfg(100, 100, 0, 1, 1, 0);
    #2;
    doReset();

    // Streaming with a 1-cycle memory
    step();
    chkb("t1_first_req", imem_req_valid, 1'b1);
    chk("t1_first_addr", imem_req_addr, 32'h0);
    step(); step();
    chk("t1_pc0", instr_pc, 32'h0);
    step();
    chk("t1_pc1", instr_pc, 32'h4);
    step();
    chk("t1_pc2", instr_pc, 32'h8);
    chkb("t1_valid", instr_valid, 1'b1);
    repeat (5) step();

    // Decode stalled: queue fills, issue stops, then drains in order
    doReset();
    cfg(100, 0, 0, 1, 1, 0);
    repeat (10) step();
    chkb("t2_stall_req", imem_req_valid, 1'b0);
    chkb("t2_full_valid", instr_valid, 1'b1);
    chk("t2_head", instr_pc, 32'h0);
    instrReadyPct = 100;
    step(); step();
    chkb("t2_resume_req", imem_req_valid, 1'b1);
    chk("t2_resume_addr", imem_req_addr, 32'h10);
    chk("t2_drain_pc1", instr_pc, 32'h4);
    repeat (6) step();

    // Redirect with three late responses in flight
    cfg(100, 100, 0, 3, 3, 0);
    repeat (6) step();
    useFixed = 1'b1; fixedTarget = 32'h100; redirPct = 100;
    step();
    redirPct = 0;
    step();
    chkb("t3_flushed", instr_valid, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (instr_valid) begin
        seen = 1'b1;
        chk("t3_first_pc", instr_pc, 32'h100);
      end
    end
    chkb("t3_seen", seen, 1'b1);

    // Redirect colliding with a response; unaligned target
    cfg(100, 100, 0, 1, 1, 0);
    repeat (4) step();
    fixedTarget = 32'h202; redirPct = 100;
    step();
    redirPct = 0;
    step();
    chk("t4_aligned", imem_req_addr, 32'h200);
    repeat (6) step();
    useFixed = 1'b0;

    // Halt mid-stream
    cfg(100, 100, 0, 2, 2, 0);
    repeat (6) step();
    haltCfg = 1;
    repeat (12) step();
    chkb("t5_halt_noreq", imem_req_valid, 1'b0);
    chkb("t5_idle", busy, 1'b0);
    haltCfg = 0;
    repeat (8) step();

    // Reset with words queued and in flight
    doReset();
    cfg(100, 0, 0, 3, 3, 0);
    repeat (6) step();
    chkb("t6_busy_before", busy, 1'b1);
    doReset();
    cfg(100, 100, 0, 1, 1, 0);
    repeat (10) step();

    // Randomized phases
    for (int ph = 0; ph < 8; ph++) begin
      if (ph == 4) doReset();
      cfg(int'($urandom_range(100, 30)), int'($urandom_range(100, 20)), int'($urandom_range(8, 0)),
          1, int'($urandom_range(5, 1)), 2);
      repeat (400) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end
endmodule
